arcade_input_mapper: RTL

Parametrised successor to the fixed two-player arcade input block used by the MiST arcade wrappers. It merges MiST joysticks with a PS/2 keyboard map for up to four players and applies screen-rotation remapping, joystick swap and single-player merge. It adds two features the fixed block lacks: SOCD (opposing-direction) resolution and minimum-length coin pulse stretching. It sits between `user_io` and the arcade core, and all its outputs are registered and active-high.

---
 rtl/arcade_inputs_pkg.sv | 108 ++++++++++
 rtl/arcade_socd.sv | 44 ++++
 rtl/arcade_input_mapper.sv | 136 +++++++++++++
 3 files changed

// File: rtl/arcade_inputs_pkg.sv
// Shared constants, scancode map and helpers for the arcade input mapper.
package arcade_inputs_pkg;

  localparam int unsigned JOY_R       = 0;
  localparam int unsigned JOY_L       = 1;
  localparam int unsigned JOY_D       = 2;
  localparam int unsigned JOY_U       = 3;
  localparam int unsigned JOY_FIRE    = 4;
  localparam int unsigned JOY_START   = 10;
  localparam int unsigned JOY_COIN    = 11;
  localparam int unsigned JOY_WIDTH   = 16;
  localparam int unsigned MAX_PLAYERS = 4;

  // Key-table slots: P0 uses joystick bit order, P1 dirs + two fires, then start/coin/tilt
  localparam int unsigned KEY_P1_BASE    = 10;
  localparam int unsigned KEY_START_BASE = 16;
  localparam int unsigned KEY_COIN_BASE  = 20;
  localparam int unsigned KEY_TILT       = 24;
  localparam int unsigned KEY_COUNT      = 25;
  localparam int unsigned KEY_IDX_W      = 5;

  // Scancodes as {extended, code}
  localparam logic [8:0] SC_P0_U    = 9'h175;
  localparam logic [8:0] SC_P0_D    = 9'h172;
  localparam logic [8:0] SC_P0_L    = 9'h16B;
  localparam logic [8:0] SC_P0_R    = 9'h174;
  localparam logic [8:0] SC_P0_A    = 9'h014;
  localparam logic [8:0] SC_P0_B    = 9'h011;
  localparam logic [8:0] SC_P0_C    = 9'h029;
  localparam logic [8:0] SC_P0_D_BT = 9'h012;
  localparam logic [8:0] SC_P0_E    = 9'h01A;
  localparam logic [8:0] SC_P0_F    = 9'h022;
  localparam logic [8:0] SC_P1_U    = 9'h02D;
  localparam logic [8:0] SC_P1_D    = 9'h02B;
  localparam logic [8:0] SC_P1_L    = 9'h023;
  localparam logic [8:0] SC_P1_R    = 9'h034;
  localparam logic [8:0] SC_P1_A    = 9'h01C;
  localparam logic [8:0] SC_P1_B    = 9'h01B;
  localparam logic [8:0] SC_START1  = 9'h016;
  localparam logic [8:0] SC_START2  = 9'h01E;
  localparam logic [8:0] SC_START3  = 9'h026;
  localparam logic [8:0] SC_START4  = 9'h025;
  localparam logic [8:0] SC_COIN1   = 9'h02E;
  localparam logic [8:0] SC_COIN2   = 9'h036;
  localparam logic [8:0] SC_COIN3   = 9'h03D;
  localparam logic [8:0] SC_COIN4   = 9'h03E;
  localparam logic [8:0] SC_TILT    = 9'h02C;

  typedef enum logic [1:0] {
    SOCD_NONE = 2'd0,
    SOCD_NEG  = 2'd1,
    SOCD_POS  = 2'd2
  } socd_state_t;

  typedef struct packed {
    logic                 hit;
    logic [KEY_IDX_W-1:0] idx;
  } key_slot_t;

  function automatic key_slot_t key_lookup(input logic ext, input logic [7:0] code);
    key_slot_t s;
    s.hit = 1'b1;
    s.idx = '0;
    case ({ext, code})
      SC_P0_R:    s.idx = KEY_IDX_W'(JOY_R);
      SC_P0_L:    s.idx = KEY_IDX_W'(JOY_L);
      SC_P0_D:    s.idx = KEY_IDX_W'(JOY_D);
      SC_P0_U:    s.idx = KEY_IDX_W'(JOY_U);
      SC_P0_A:    s.idx = KEY_IDX_W'(JOY_FIRE + 0);
      SC_P0_B:    s.idx = KEY_IDX_W'(JOY_FIRE + 1);
      SC_P0_C:    s.idx = KEY_IDX_W'(JOY_FIRE + 2);
      SC_P0_D_BT: s.idx = KEY_IDX_W'(JOY_FIRE + 3);
      SC_P0_E:    s.idx = KEY_IDX_W'(JOY_FIRE + 4);
      SC_P0_F:    s.idx = KEY_IDX_W'(JOY_FIRE + 5);
      SC_P1_R:    s.idx = KEY_IDX_W'(KEY_P1_BASE + JOY_R);
      SC_P1_L:    s.idx = KEY_IDX_W'(KEY_P1_BASE + JOY_L);
      SC_P1_D:    s.idx = KEY_IDX_W'(KEY_P1_BASE + JOY_D);
      SC_P1_U:    s.idx = KEY_IDX_W'(KEY_P1_BASE + JOY_U);
      SC_P1_A:    s.idx = KEY_IDX_W'(KEY_P1_BASE + JOY_FIRE);
      SC_P1_B:    s.idx = KEY_IDX_W'(KEY_P1_BASE + JOY_FIRE + 1);
      SC_START1:  s.idx = KEY_IDX_W'(KEY_START_BASE + 0);
      SC_START2:  s.idx = KEY_IDX_W'(KEY_START_BASE + 1);
      SC_START3:  s.idx = KEY_IDX_W'(KEY_START_BASE + 2);
      SC_START4:  s.idx = KEY_IDX_W'(KEY_START_BASE + 3);
      SC_COIN1:   s.idx = KEY_IDX_W'(KEY_COIN_BASE + 0);
      SC_COIN2:   s.idx = KEY_IDX_W'(KEY_COIN_BASE + 1);
      SC_COIN3:   s.idx = KEY_IDX_W'(KEY_COIN_BASE + 2);
      SC_COIN4:   s.idx = KEY_IDX_W'(KEY_COIN_BASE + 3);
      SC_TILT:    s.idx = KEY_IDX_W'(KEY_TILT);
      default:    s.hit = 1'b0;
    endcase
    return s;
  endfunction

  // Direction nibble is {U, D, L, R}; rotate first, then the 180-degree flip
  function automatic logic [3:0] remap_dirs(input logic [3:0] d, input logic rot,
                                            input logic [1:0] orient);
    logic [3:0] r;
    r = d;
    if (rot) begin
      if (orient[0]) r = {d[JOY_R], d[JOY_L], d[JOY_U], d[JOY_D]};
      else           r = {d[JOY_L], d[JOY_R], d[JOY_D], d[JOY_U]};
    end
    if (orient[1]) r = {r[JOY_D], r[JOY_U], r[JOY_R], r[JOY_L]};
    return r;
  endfunction

endpackage

// File: rtl/arcade_socd.sv
// Single-axis opposing-direction resolver: cancel, or last-risen direction wins.
module arcade_socd
  import arcade_inputs_pkg::*;
#(
  parameter int unsigned SOCD_LAST = 0
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic neg,
  input  logic pos,
  output logic neg_c,
  output logic pos_c
);

  socd_state_t state, state_next;
  logic        neg_q, pos_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= SOCD_NONE;
      neg_q <= 1'b0;
      pos_q <= 1'b0;
    end else begin
      state <= state_next;
      neg_q <= neg;
      pos_q <= pos;
    end
  end

  // Simultaneous rises leave no winner until one side releases
  always_comb begin
    state_next = state;
    neg_c      = neg;
    pos_c      = pos;
    if (neg && !neg_q && pos && !pos_q) state_next = SOCD_NONE;
    else if (neg && !neg_q)             state_next = SOCD_NEG;
    else if (pos && !pos_q)             state_next = SOCD_POS;
    if (neg && pos) begin
      neg_c = (SOCD_LAST != 0) && (state_next == SOCD_NEG);
      pos_c = (SOCD_LAST != 0) && (state_next == SOCD_POS);
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges MiST joysticks and a PS/2 key map per player, with rotation, swap,
// single-player merge, SOCD resolution and coin pulse stretching.
module arcade_input_mapper
  import arcade_inputs_pkg::*;
#(
  parameter int unsigned PLAYERS    = 2,
  parameter int unsigned BUTTONS    = 6,
  parameter int unsigned SOCD_LAST  = 0,
  parameter int unsigned COIN_PULSE = 1200000
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic                            key_strobe,
  input  logic                            key_pressed,
  input  logic                            key_extended,
  input  logic [7:0]                      key_code,
  input  logic [PLAYERS*JOY_WIDTH-1:0]    joystick,
  input  logic                            rotate,
  input  logic [1:0]                      orientation,
  input  logic                            joyswap,
  input  logic                            oneplayer,
  output logic [PLAYERS-1:0]              start,
  output logic [PLAYERS-1:0]              coin,
  output logic                            tilt,
  output logic [PLAYERS*(4+BUTTONS)-1:0]  player
);

  localparam int unsigned FW = 4 + BUTTONS;
  localparam int unsigned CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_PULSE - 1);

  logic [KEY_COUNT-1:0]                       key_tab;
  key_slot_t                                  slot_c;
  logic [MAX_PLAYERS-1:0][JOY_WIDTH-1:0]      key_word;
  logic [MAX_PLAYERS-1:0][JOY_WIDTH-1:0]      src;
  logic [JOY_WIDTH-1:0]                       merged;
  logic [PLAYERS-1:0]                         start_c;
  logic [PLAYERS-1:0]                         coin_c;
  logic [PLAYERS*FW-1:0]                      player_c;
  logic                                       unused_top;

  assign slot_c = key_lookup(key_extended, key_code);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) key_tab <= '0;
    else if (key_strobe && slot_c.hit) key_tab[slot_c.idx] <= key_pressed;
  end

  assign merged     = src[0] | src[1] | src[2] | src[3];
  assign unused_top = ^{key_tab, joystick};

  for (genvar p = 0; p < int'(MAX_PLAYERS); p++) begin : g_key
    if (p == 0) begin : g_p0
      assign key_word[p][JOY_FIRE+5:0] = key_tab[JOY_FIRE+5:0];
    end else if (p == 1) begin : g_p1
      assign key_word[p][JOY_FIRE+5:0] = {4'b0, key_tab[KEY_P1_BASE +: 6]};
    end else begin : g_pn
      assign key_word[p][JOY_FIRE+5:0] = '0;
    end
    assign key_word[p][JOY_START] = key_tab[KEY_START_BASE + p];
    assign key_word[p][JOY_COIN]  = key_tab[KEY_COIN_BASE + p];
    assign key_word[p][JOY_WIDTH-1:JOY_COIN+1] = '0;
  end

  for (genvar p = 0; p < int'(MAX_PLAYERS); p++) begin : g_player
    if (p < int'(PLAYERS)) begin : g_live
      localparam int unsigned ALT = (PLAYERS > 1 && p < 2) ? 1 - p : p;
      logic [JOY_WIDTH-1:0] joy_w, play_w;
      logic [3:0]           dirs;
      logic                 up_c, down_c, left_c, right_c;
      logic                 coin_raw, coin_prev;
      logic [CW-1:0]        coin_cnt;
      logic                 unused_play;

      assign joy_w  = joyswap ? joystick[JOY_WIDTH*ALT +: JOY_WIDTH]
                              : joystick[JOY_WIDTH*p +: JOY_WIDTH];
      assign src[p] = joy_w | key_word[p];
      assign play_w = oneplayer ? merged : src[p];
      assign dirs   = remap_dirs(play_w[3:0], rotate, orientation);
      assign unused_play = ^play_w;

      arcade_socd #(.SOCD_LAST(SOCD_LAST)) u_socd_x (
        .clk_sys (clk_sys),
        .reset   (reset),
        .neg     (dirs[JOY_L]),
        .pos     (dirs[JOY_R]),
        .neg_c   (left_c),
        .pos_c   (right_c)
      );

      arcade_socd #(.SOCD_LAST(SOCD_LAST)) u_socd_y (
        .clk_sys (clk_sys),
        .reset   (reset),
        .neg     (dirs[JOY_U]),
        .pos     (dirs[JOY_D]),
        .neg_c   (up_c),
        .pos_c   (down_c)
      );

      assign player_c[FW*p +: FW] = {play_w[JOY_FIRE +: BUTTONS], up_c, down_c, left_c, right_c};
      assign start_c[p]           = src[p][JOY_START];
      assign coin_raw             = src[p][JOY_COIN];

      // Each new coin rise restarts the minimum-length stretch
      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
          coin_prev <= 1'b0;
          coin_cnt  <= '0;
        end else begin
          coin_prev <= coin_raw;
          if (coin_raw && !coin_prev) coin_cnt <= COIN_LOAD;
          else if (coin_cnt != '0)    coin_cnt <= coin_cnt - CW'(1);
        end
      end

      assign coin_c[p] = coin_raw | (coin_cnt != '0);
    end else begin : g_absent
      assign src[p] = '0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      start  <= '0;
      coin   <= '0;
      tilt   <= 1'b0;
      player <= '0;
    end else begin
      start  <= start_c;
      coin   <= coin_c;
      tilt   <= key_tab[KEY_TILT];
      player <= player_c;
    end
  end

endmodule
